inst_mem_loader: RTL and testbench

Serial program loader: the write side of the instruction memory. It accepts a byte stream and assembles it into 32-bit little-endian instruction words. It writes those words into a writable instruction memory at word-aligned byte addresses, which the fetch stage reads back as `pc >> 2`. It holds the CPU off while loading and checks a length header and an XOR checksum.

---
 rtl/inst_mem_loader.sv | 121 ++++++++++++
 tb/tb_inst_mem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Serial program loader: assembles a length-prefixed, XOR-checksummed byte stream
// into little-endian 32-bit words and writes them into the instruction memory.
module inst_mem_loader #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);
   localparam int IW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, FAIL} state_t;

   state_t        state, state_nxt;
   logic [7:0]    len_lo;
   logic [15:0]   len;
   logic [IW-1:0] word_idx;
   logic [1:0]    bcnt;
   logic [7:0]    csum;
   logic [23:0]   wbuf;
   logic          xfer;
   logic          start_ok;
   logic          last_word;
   logic [15:0]   n_hdr;

   assign xfer      = byte_valid && byte_ready;
   assign start_ok  = load_start && (state == IDLE);
   assign n_hdr     = {byte_data, len_lo};
   assign last_word = ((16'(word_idx) + 16'd1) == len);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load_start) state_nxt = LEN0;
         LEN0: if (xfer) state_nxt = LEN1;
         LEN1: begin
            if (xfer) begin
               if (n_hdr > 16'(DEPTH))  state_nxt = FAIL;
               else if (n_hdr == 16'd0) state_nxt = CSUM;
               else                     state_nxt = DATA;
            end
         end
         DATA: if (xfer && (bcnt == 2'd3) && last_word) state_nxt = CSUM;
         CSUM: if (xfer) state_nxt = (byte_data == csum) ? DONE : FAIL;
         DONE: state_nxt = IDLE;
         FAIL: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      cpu_hold   = 1'b0;
      load_done  = 1'b0;
      case (state)
         LEN0, LEN1, DATA, CSUM: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
         end
         DONE, FAIL: begin
            cpu_hold  = 1'b1;
            load_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Control and write-port registers; the write strobe lags the 4th byte by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_idx  <= '0;
         bcnt      <= 2'd0;
         csum      <= 8'd0;
         load_err  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (start_ok) begin
            word_idx <= '0;
            bcnt     <= 2'd0;
            csum     <= 8'd0;
            load_err <= 1'b0;
         end
         if (xfer) csum <= csum ^ byte_data;
         if (xfer && (state == DATA)) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
               mem_we    <= 1'b1;
               mem_addr  <= 32'(word_idx) << 2;
               mem_wdata <= {byte_data, wbuf};
               word_idx  <= word_idx + 1'b1;
            end
         end
         if ((state_nxt == FAIL) && (state != FAIL)) load_err <= 1'b1;
      end
   end

   // Header and partial-word holding registers carry data only, so they are not reset.
   always_ff @(posedge clk) begin
      if (xfer && (state == LEN0)) len_lo <= byte_data;
      if (xfer && (state == LEN1)) len <= n_hdr;
      if (xfer && (state == DATA) && (bcnt != 2'd3)) wbuf[8*bcnt +: 8] <= byte_data;
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected writes are queued when a stream is
// driven and compared as mem_we strobes appear.
module tb_inst_mem_loader;
   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready, mem_we, cpu_hold, load_done, load_err;
   logic [31:0] mem_addr, mem_wdata;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          done_base = 0;
   logic        last_err = 1'b0;
   logic        hold_bad = 1'b0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   inst_mem_loader #(.DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 64'd0 - 64'd1);
         else                   chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
      if (load_done) begin
         done_cnt++;
         last_err = load_err;
      end
   end

   task automatic do_start();
      done_base = done_cnt;
      hold_bad  = 1'b0;
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit thr);
      int n = 0;
      if (thr) begin
         while (($urandom_range(0, 1) == 1) && (n < 6)) begin
            byte_valid = 1'b0;
            @(negedge clk);
            n++;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         chk("ready_timeout", 64'd0, 64'd1);
         byte_valid = 1'b0;
         return;
      end
      if (!cpu_hold) hold_bad = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_stream(input bq_t s, input bit thr, input int poke, input int count);
      for (int i = 0; i < count; i++) begin
         if (i == poke) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
         end
         send_byte(s[i], thr);
      end
   endtask

   task automatic finish_load(input string tag, input logic exp_err);
      int n = 0;
      while ((done_cnt == done_base) && (n < 20)) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
      chk({tag, "_err"}, 64'(last_err), 64'(exp_err));
      chk({tag, "_hold_during"}, 64'(hold_bad), 64'd0);
      chk({tag, "_hold_after"}, 64'(cpu_hold), 64'd0);
      chk({tag, "_ready_after"}, 64'(byte_ready), 64'd0);
      chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
      chk({tag, "_mem_we"},     64'(mem_we), 64'd0);
      chk({tag, "_mem_addr"},   64'(mem_addr), 64'd0);
      chk({tag, "_mem_wdata"},  64'(mem_wdata), 64'd0);
      chk({tag, "_cpu_hold"},   64'(cpu_hold), 64'd0);
      chk({tag, "_load_done"},  64'(load_done), 64'd0);
      chk({tag, "_load_err"},   64'(load_err), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t nominal, bad, zero, over, full;
      logic [7:0]  cs;
      logic [31:0] w;

      nominal = '{8'h02, 8'h00, 8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3, 8'h0D};
      bad     = '{8'h02, 8'h00, 8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3, 8'h0C};
      zero    = '{8'h00, 8'h00, 8'h00};
      over    = '{8'h41, 8'h00};

      // Reset state
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal, back-to-back
      exp_q.push_back({32'h0, 32'hE3A00014});
      exp_q.push_back({32'h4, 32'hE3A01A01});
      do_start();
      send_stream(nominal, 1'b0, -1, 11);
      finish_load("nominal", 1'b0);

      // Checksum mismatch: writes still happen, error is sticky
      exp_q.push_back({32'h0, 32'hE3A00014});
      exp_q.push_back({32'h4, 32'hE3A01A01});
      do_start();
      send_stream(bad, 1'b0, -1, 11);
      finish_load("csum_bad", 1'b1);
      repeat (3) @(negedge clk);
      chk("csum_bad_sticky", 64'(load_err), 64'd1);

      // N = 0; starting it clears the sticky error
      do_start();
      chk("err_cleared_on_start", 64'(load_err), 64'd0);
      send_stream(zero, 1'b0, -1, 3);
      finish_load("len_zero", 1'b0);

      // N = 65 exceeds depth
      do_start();
      send_stream(over, 1'b0, -1, 2);
      finish_load("len_over", 1'b1);
      chk("len_over_err_level", 64'(load_err), 64'd1);

      // Throttled sender with a stray load_start in DATA
      exp_q.push_back({32'h0, 32'hE3A00014});
      exp_q.push_back({32'h4, 32'hE3A01A01});
      do_start();
      send_stream(nominal, 1'b1, 5, 11);
      finish_load("throttled", 1'b0);

      // Reset after the 6th byte: word 0 still lands, word 1 never does
      exp_q.push_back({32'h0, 32'hE3A00014});
      do_start();
      send_stream(nominal, 1'b0, -1, 6);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midreset_writes_left", 64'(exp_q.size()), 64'd0);
      exp_q.push_back({32'h0, 32'hE3A00014});
      exp_q.push_back({32'h4, 32'hE3A01A01});
      do_start();
      send_stream(nominal, 1'b0, -1, 11);
      finish_load("after_reset", 1'b0);

      // Full depth, N = 64, word k = k * 0x01010101
      full = '{8'h40, 8'h00};
      cs = 8'h40;
      for (int k = 0; k < 64; k++) begin
         w = 32'(k) * 32'h01010101;
         exp_q.push_back({32'(k * 4), w});
         for (int j = 0; j < 4; j++) begin
            full.push_back(w[8*j +: 8]);
            cs = cs ^ w[8*j +: 8];
         end
      end
      full.push_back(cs);
      do_start();
      send_stream(full, 1'b0, -1, full.size());
      finish_load("full_depth", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
